// File: rtl/comparator_scan_sequencer_if.sv
// Signal bundle between the comparator scan sequencer and its host/pulser side.
// The slave modport is the sequencer's view; master is the driving environment.
interface comparator_scan_sequencer_if;
    logic        start;
    logic        abort;
    logic [4:0]  strip_first;
    logic [4:0]  strip_last;
    logic [15:0] num_pulses;
    logic        pulser_ready;
    logic [31:0] thresholds_errcnt;
    logic [31:0] offsets_errcnt;
    logic [31:0] compout_errcnt;
    logic        fire_pulse;
    logic [31:0] active_strip_mask;
    logic [31:0] halfstrips_expect;
    logic        errcnt_rst;
    logic        busy;
    logic        done;
    logic        hang_err;
    logic        result_valid;
    logic [4:0]  result_strip;
    logic [31:0] result_thr;
    logic [31:0] result_ofs;
    logic [31:0] result_cmp;

    modport slave (
        input  start, abort, strip_first, strip_last, num_pulses, pulser_ready,
               thresholds_errcnt, offsets_errcnt, compout_errcnt,
        output fire_pulse, active_strip_mask, halfstrips_expect, errcnt_rst,
               busy, done, hang_err, result_valid, result_strip,
               result_thr, result_ofs, result_cmp
    );

    modport master (
        output start, abort, strip_first, strip_last, num_pulses, pulser_ready,
               thresholds_errcnt, offsets_errcnt, compout_errcnt,
        input  fire_pulse, active_strip_mask, halfstrips_expect, errcnt_rst,
               busy, done, hang_err, result_valid, result_strip,
               result_thr, result_ofs, result_cmp
    );
endinterface

// File: rtl/comparator_scan_sequencer.sv
// Walks a strip range, firing a handshaked pulse train per strip and reporting the
// pulser error counters after each strip. All outputs are registered.
module comparator_scan_sequencer #(
    parameter int HANG_TIMEOUT  = 255,
    parameter int SETTLE_CYCLES = 3
) (
    input logic                         clk,
    input logic                         rst_n,
    comparator_scan_sequencer_if.slave  bus
);

    localparam int HW = $clog2(HANG_TIMEOUT + 1) + 1;
    localparam int SW = $clog2(SETTLE_CYCLES + 1) + 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETUP   = 3'd1,
        S_ARM     = 3'd2,
        S_FIRE    = 3'd3,
        S_RELEASE = 3'd4,
        S_SETTLE  = 3'd5,
        S_REPORT  = 3'd6,
        S_DONE    = 3'd7
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  strip_q, strip_d;
    logic [4:0]  last_q, last_d;
    logic [15:0] npulse_q, npulse_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [HW-1:0] hang_q, hang_d;
    logic [SW-1:0] settle_q, settle_d;
    logic        fire_q, fire_d;
    logic        busy_q, busy_d;
    logic        errcnt_rst_q, errcnt_rst_d;
    logic        done_q, done_d;
    logic        hang_err_q, hang_err_d;
    logic [31:0] mask_q, mask_d;
    logic        rv_q, rv_d;
    logic [4:0]  rstrip_q, rstrip_d;
    logic [31:0] thr_q, thr_d;
    logic [31:0] ofs_q, ofs_d;
    logic [31:0] cmp_q, cmp_d;
    logic [16:0] pcnt_inc_s;
    logic        hang_expired_s;
    logic        settle_expired_s;

    function automatic logic is_wait(input state_e s);
        return (s == S_ARM) || (s == S_FIRE) || (s == S_RELEASE);
    endfunction

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d          = state_q;
        strip_d          = strip_q;
        last_d           = last_q;
        npulse_d         = npulse_q;
        pcnt_d           = pcnt_q;
        hang_err_d       = 1'b0;
        mask_d           = mask_q;
        rstrip_d         = rstrip_q;
        thr_d            = thr_q;
        ofs_d            = ofs_q;
        cmp_d            = cmp_q;
        pcnt_inc_s       = {1'b0, pcnt_q} + 17'd1;
        hang_expired_s   = (int'(hang_q) + 1) >= HANG_TIMEOUT;
        settle_expired_s = (int'(settle_q) + 1) >= SETTLE_CYCLES;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    last_d   = bus.strip_last;
                    npulse_d = (bus.num_pulses == 16'd0) ? 16'd1 : bus.num_pulses;
                    strip_d  = bus.strip_first;
                    state_d  = (bus.strip_first > bus.strip_last) ? S_DONE : S_SETUP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SETUP: begin
                pcnt_d  = 16'd0;
                mask_d  = 32'd1 << strip_q;
                state_d = S_ARM;
            end
            S_ARM: begin
                if (bus.pulser_ready) begin
                    state_d = S_FIRE;
                end else if (hang_expired_s) begin
                    state_d    = S_IDLE;
                    hang_err_d = 1'b1;
                end else begin
                    state_d = S_ARM;
                end
            end
            S_FIRE: begin
                if (!bus.pulser_ready) begin
                    state_d = S_RELEASE;
                end else if (hang_expired_s) begin
                    state_d    = S_IDLE;
                    hang_err_d = 1'b1;
                end else begin
                    state_d = S_FIRE;
                end
            end
            S_RELEASE: begin
                // 17-bit compare so num_pulses=65535 terminates without the count wrapping.
                if (bus.pulser_ready) begin
                    pcnt_d  = pcnt_inc_s[15:0];
                    state_d = (pcnt_inc_s == {1'b0, npulse_q}) ? S_SETTLE : S_ARM;
                end else if (hang_expired_s) begin
                    state_d    = S_IDLE;
                    hang_err_d = 1'b1;
                end else begin
                    state_d = S_RELEASE;
                end
            end
            S_SETTLE: begin
                state_d = settle_expired_s ? S_REPORT : S_SETTLE;
            end
            S_REPORT: begin
                if (strip_q == last_q) begin
                    state_d = S_DONE;
                end else begin
                    strip_d = strip_q + 5'd1;
                    state_d = S_SETUP;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (bus.abort && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            hang_err_d = 1'b0;
        end else begin
            state_d = state_d;
        end

        hang_d   = (is_wait(state_q) && (state_d == state_q)) ? hang_q + HW'(1) : HW'(0);
        settle_d = ((state_q == S_SETTLE) && (state_d == S_SETTLE)) ? settle_q + SW'(1) : SW'(0);

        // Status outputs are decoded from the next state so they line up with the state register.
        fire_d       = (state_d == S_FIRE);
        busy_d       = (state_d != S_IDLE);
        errcnt_rst_d = (state_d == S_SETUP);
        done_d       = (state_d == S_DONE);

        rv_d = (state_q == S_REPORT) && !bus.abort;
        if (rv_d) begin
            rstrip_d = strip_q;
            thr_d    = bus.thresholds_errcnt;
            ofs_d    = bus.offsets_errcnt;
            cmp_d    = bus.compout_errcnt;
        end else begin
            rstrip_d = rstrip_q;
        end
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            strip_q      <= 5'd0;
            last_q       <= 5'd0;
            npulse_q     <= 16'd0;
            pcnt_q       <= 16'd0;
            hang_q       <= HW'(0);
            settle_q     <= SW'(0);
            fire_q       <= 1'b0;
            busy_q       <= 1'b0;
            errcnt_rst_q <= 1'b0;
            done_q       <= 1'b0;
            hang_err_q   <= 1'b0;
            mask_q       <= 32'd0;
            rv_q         <= 1'b0;
            rstrip_q     <= 5'd0;
            thr_q        <= 32'd0;
            ofs_q        <= 32'd0;
            cmp_q        <= 32'd0;
        end else begin
            state_q      <= state_d;
            strip_q      <= strip_d;
            last_q       <= last_d;
            npulse_q     <= npulse_d;
            pcnt_q       <= pcnt_d;
            hang_q       <= hang_d;
            settle_q     <= settle_d;
            fire_q       <= fire_d;
            busy_q       <= busy_d;
            errcnt_rst_q <= errcnt_rst_d;
            done_q       <= done_d;
            hang_err_q   <= hang_err_d;
            mask_q       <= mask_d;
            rv_q         <= rv_d;
            rstrip_q     <= rstrip_d;
            thr_q        <= thr_d;
            ofs_q        <= ofs_d;
            cmp_q        <= cmp_d;
        end
    end

    assign bus.fire_pulse        = fire_q;
    assign bus.active_strip_mask = mask_q;
    assign bus.halfstrips_expect = mask_q;
    assign bus.errcnt_rst        = errcnt_rst_q;
    assign bus.busy              = busy_q;
    assign bus.done              = done_q;
    assign bus.hang_err          = hang_err_q;
    assign bus.result_valid      = rv_q;
    assign bus.result_strip      = rstrip_q;
    assign bus.result_thr        = thr_q;
    assign bus.result_ofs        = ofs_q;
    assign bus.result_cmp        = cmp_q;

endmodule
